// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter in front of one synchronous SRAM port.
// One transaction at a time: IDLE -> ISSUE -> (CAPTURE on reads) -> ACK.
// Ports:
//   Clk, Rst              clock, async active-high reset
//   Req/RW/Addr/WData0,1  requester inputs (RW: 1=write)
//   Ack0, Ack1            one-cycle completion pulse per requester
//   RData                 shared read data, valid with the matching Ack
//   Busy                  high whenever not IDLE
//   Mem_En/RW/Addr/Data_In  SRAM command, Mem_Data_Out SRAM read data
// Config: define SRAM_ARB_RR_EN for round-robin ties; else port 0 wins ties.
module sram_arbiter #(
    parameter int A_WIDTH = 13,
    parameter int D_WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Req0,
    input  logic               Req1,
    input  logic               RW0,
    input  logic               RW1,
    input  logic [A_WIDTH-1:0] Addr0,
    input  logic [A_WIDTH-1:0] Addr1,
    input  logic [D_WIDTH-1:0] WData0,
    input  logic [D_WIDTH-1:0] WData1,
    output logic               Ack0,
    output logic               Ack1,
    output logic [D_WIDTH-1:0] RData,
    output logic               Busy,
    output logic               Mem_En,
    output logic               Mem_RW,
    output logic [A_WIDTH-1:0] Mem_Addr,
    output logic [D_WIDTH-1:0] Mem_Data_In,
    input  logic [D_WIDTH-1:0] Mem_Data_Out
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        ACK
    } state_e;

    state_e             state_q;
    logic               win_q;
    logic               rw_q;
    logic [A_WIDTH-1:0] addr_q;
    logic [D_WIDTH-1:0] wdata_q;
    logic               en_q;
    logic               ack0_q;
    logic               ack1_q;
    logic [D_WIDTH-1:0] rdata_q;

    logic               win_d;
    logic               rw_d;
    logic [A_WIDTH-1:0] addr_d;
    logic [D_WIDTH-1:0] wdata_d;

`ifdef SRAM_ARB_RR_EN
    // Port granted most recently; a tie goes to the other one.
    logic               last_q;
    assign win_d = Req1 & (~Req0 | ~last_q);
`else
    assign win_d = Req1 & ~Req0;
`endif

    always_comb begin
        rw_d    = RW0;
        addr_d  = Addr0;
        wdata_d = WData0;
        if (win_d) begin
            rw_d    = RW1;
            addr_d  = Addr1;
            wdata_d = WData1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            en_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rdata_q <= '0;
`ifdef SRAM_ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            // Enable and acks are single-cycle pulses by default.
            en_q   <= 1'b0;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (Req0 | Req1) begin
                        win_q   <= win_d;
                        rw_q    <= rw_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        en_q    <= 1'b1;
                        state_q <= ISSUE;
`ifdef SRAM_ARB_RR_EN
                        last_q  <= win_d;
`endif
                    end
                end
                ISSUE: begin
                    if (rw_q) begin
                        ack0_q  <= ~win_q;
                        ack1_q  <= win_q;
                        state_q <= ACK;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // SRAM presents read data one cycle after enable.
                    rdata_q <= Mem_Data_Out;
                    ack0_q  <= ~win_q;
                    ack1_q  <= win_q;
                    state_q <= ACK;
                end
                ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Ack0        = ack0_q;
    assign Ack1        = ack1_q;
    assign RData       = rdata_q;
    assign Busy        = (state_q != IDLE);
    assign Mem_En      = en_q;
    assign Mem_RW      = rw_q;
    assign Mem_Addr    = addr_q;
    assign Mem_Data_In = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: random and directed stimulus for sram_arbiter
// against a transaction-level reference model and a simple SRAM model.
module tb_sram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          Req0 = 1'b0;
    logic          Req1 = 1'b0;
    logic          RW0 = 1'b0;
    logic          RW1 = 1'b0;
    logic [AW-1:0] Addr0 = '0;
    logic [AW-1:0] Addr1 = '0;
    logic [DW-1:0] WData0 = '0;
    logic [DW-1:0] WData1 = '0;
    logic          Ack0;
    logic          Ack1;
    logic [DW-1:0] RData;
    logic          Busy;
    logic          Mem_En;
    logic          Mem_RW;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_Data_In;
    logic [DW-1:0] Mem_Data_Out;

    always #5 Clk = ~Clk;

    sram_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Req0(Req0),
        .Req1(Req1),
        .RW0(RW0),
        .RW1(RW1),
        .Addr0(Addr0),
        .Addr1(Addr1),
        .WData0(WData0),
        .WData1(WData1),
        .Ack0(Ack0),
        .Ack1(Ack1),
        .RData(RData),
        .Busy(Busy),
        .Mem_En(Mem_En),
        .Mem_RW(Mem_RW),
        .Mem_Addr(Mem_Addr),
        .Mem_Data_In(Mem_Data_In),
        .Mem_Data_Out(Mem_Data_Out)
    );

    // SRAM: registered read data, zero except in the cycle after a read enable.
    logic [DW-1:0] sram [1<<AW];
    logic [DW-1:0] sram_q;
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sram_q <= '0;
        end else begin
            sram_q <= (Mem_En && !Mem_RW) ? sram[Mem_Addr] : '0;
            if (Mem_En && Mem_RW) sram[Mem_Addr] <= Mem_Data_In;
        end
    end
    assign Mem_Data_Out = sram_q;

    typedef struct {
        bit            rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    op_t           q0[$];
    op_t           q1[$];
    logic [AW-1:0] waddrs[$];
    logic [DW-1:0] mm [1<<AW];
    int            gnt_log[$];

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            g_cyc, ack_cyc, nxt;
    int            en_cnt = 0;
    bit            e_w, e_rw, m_last;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data, rd_exp, last_rd;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        g_cyc   = -10;
        ack_cyc = -10;
        nxt     = cyc + 1;
        e_w     = 1'b0;
        e_rw    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
        rd_exp  = '0;
        m_last  = 1'b0;
    endtask

    task automatic chk_rst(string tag);
        chk({tag, "_ack0"}, Ack0, 0);
        chk({tag, "_ack1"}, Ack1, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_men"}, Mem_En, 0);
        chk({tag, "_mrw"}, Mem_RW, 0);
        chk({tag, "_maddr"}, Mem_Addr, 0);
        chk({tag, "_mdin"}, Mem_Data_In, 0);
        chk({tag, "_rdata"}, RData, 0);
    endtask

    task automatic drv0();
        Req0 = (q0.size() != 0);
        if (q0.size() != 0) begin
            RW0    = q0[0].rw;
            Addr0  = q0[0].addr;
            WData0 = q0[0].data;
        end
    endtask

    task automatic drv1();
        Req1 = (q1.size() != 0);
        if (q1.size() != 0) begin
            RW1    = q1[0].rw;
            Addr1  = q1[0].addr;
            WData1 = q1[0].data;
        end
    endtask

    task automatic load(int p, bit rw, logic [AW-1:0] a, logic [DW-1:0] d);
        op_t o;
        o.rw   = rw;
        o.addr = a;
        o.data = d;
        if (rw) waddrs.push_back(a);
        if (p == 0) q0.push_back(o);
        else q1.push_back(o);
    endtask

    // One clock: model decides grants from the sampled requests, then
    // all outputs are compared shortly after the edge.
    task automatic step();
        bit a0, a1, w;
        @(posedge Clk);
        cyc++;
        if (cyc >= nxt && (Req0 || Req1)) begin
            if (Req0 && Req1) w = RR ? !m_last : 1'b0;
            else w = Req1;
            m_last  = w;
            e_w     = w;
            g_cyc   = cyc;
            e_rw    = w ? RW1 : RW0;
            e_addr  = w ? Addr1 : Addr0;
            e_data  = w ? WData1 : WData0;
            ack_cyc = cyc + (e_rw ? 1 : 2);
            nxt     = ack_cyc + 2;
            if (e_rw) mm[e_addr] = e_data;
        end
        #1;
        a0 = Ack0;
        a1 = Ack1;
        if (cyc == ack_cyc && !e_rw) rd_exp = mm[e_addr];
        chk("ack0", a0, (cyc == ack_cyc) && !e_w);
        chk("ack1", a1, (cyc == ack_cyc) && e_w);
        chk("busy", Busy, (cyc >= g_cyc) && (cyc <= ack_cyc));
        chk("mem_en", Mem_En, cyc == g_cyc);
        chk("mem_addr", Mem_Addr, e_addr);
        chk("mem_rw", Mem_RW, e_rw);
        chk("mem_din", Mem_Data_In, e_data);
        chk("rdata", RData, rd_exp);
        if (Mem_En) en_cnt++;
        if (a0 || a1) begin
            gnt_log.push_back(a1 ? 1 : 0);
            last_rd = RData;
        end
        if (a0 && q0.size() != 0) void'(q0.pop_front());
        if (a1 && q1.size() != 0) void'(q1.pop_front());
        if (a0 || !Req0) drv0();
        if (a1 || !Req1) drv1();
        // Payload wiggle while port 0 is being served must be ignored.
        if (cyc == g_cyc && !e_w && Req0) Addr0 = AW'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        if (!Req0) drv0();
        if (!Req1) drv1();
        while ((q0.size() != 0 || q1.size() != 0 || cyc <= ack_cyc) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("timeout", 1, 0);
        step();
        step();
    endtask

    task automatic do_reset();
        Rst  = 1'b1;
        Req0 = 1'b0;
        Req1 = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) begin
            @(posedge Clk);
            cyc++;
        end
        #1;
        chk_rst("reset");
        Rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, na, nb, base;
        bit rw;
        logic [AW-1:0] a;
        for (int i = 0; i < (1 << AW); i++) mm[i] = '0;
        model_reset();
        do_reset();

        // Tie straight out of reset.
        gnt_log.delete();
        load(0, 1'b1, 13'h0100, 8'h11);
        load(1, 1'b1, 13'h0200, 8'h22);
        drain();
        chk("tie_count", gnt_log.size(), 2);
        chk("tie_first", gnt_log[0], RR ? 1 : 0);
        chk("tie_second", gnt_log[1], RR ? 0 : 1);

        // Write then read back on port 0.
        base = en_cnt;
        load(0, 1'b1, 13'h0010, 8'hA5);
        drain();
        load(0, 1'b0, 13'h0010, 8'h00);
        drain();
        chk("wr_rd_data", last_rd, 8'hA5);
        chk("wr_rd_en_pulses", en_cnt - base, 2);

        // Boundary address, with an intervening write before the read.
        load(1, 1'b1, 13'h1FFF, 8'hFF);
        drain();
        load(1, 1'b1, 13'h0555, 8'h3C);
        drain();
        gnt_log.delete();
        load(0, 1'b0, 13'h1FFF, 8'h00);
        drain();
        chk("bound_data", last_rd, 8'hFF);
        chk("bound_port", gnt_log[0], 0);

        // Starvation: both ports keep requesting.
        do_reset();
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            load(0, 1'b1, AW'(13'h0300 + i), DW'(i));
            load(1, 1'b1, AW'(13'h0400 + i), DW'(8'h80 + i));
        end
        drain();
        chk("starve_count", gnt_log.size(), 8);
        for (int i = 0; i < 5; i++)
            chk($sformatf("starve_%0d", i), gnt_log[i],
                RR ? ((i % 2 == 0) ? 1 : 0) : ((i >= 4) ? 1 : 0));

        // Random traffic.
        repeat (30) begin
            na = $urandom_range(0, 3);
            nb = $urandom_range(0, 3);
            if (na + nb == 0) na = 1;
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < ((p == 0) ? na : nb); k++) begin
                    rw = ($urandom_range(0, 1) == 1);
                    if (rw) a = AW'($urandom);
                    else a = waddrs[$urandom_range(0, waddrs.size() - 1)];
                    load(p, rw, a, DW'($urandom));
                end
            end
            drain();
        end

        // Reset while a read sits in CAPTURE.
        load(0, 1'b0, 13'h0010, 8'h00);
        n = 0;
        if (!Req0) drv0();
        while (!(cyc == g_cyc + 1 && !e_rw) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("capture_timeout", 1, 0);
        Rst = 1'b1;
        #1;
        chk_rst("midread");
        Req0 = 1'b0;
        q0.delete();
        repeat (2) begin
            @(posedge Clk);
            cyc++;
        end
        #1;
        Rst = 1'b0;
        model_reset();
        n = gnt_log.size();
        repeat (8) step();
        chk("no_ack_after_rst", gnt_log.size(), n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL be parameterised: A_WIDTH, 13, SRAM address width.
REQ-002 The block SHALL be parameterised: D_WIDTH, 8, SRAM data width.
REQ-003 Ports SHALL be, one per line (name  direction  width  meaning):
  Clk  in  1  single clock; all state updates on rising edge
  Rst  in  1  asynchronous, active-high reset
  Req0, Req1  in  1  request from requester 0 / 1
  RW0, RW1  in  1  1=write, 0=read
  Addr0, Addr1  in  A_WIDTH  request address
  WData0, WData1  in  D_WIDTH  write data
  Ack0, Ack1  out  1  one-cycle completion pulse
  RData  out  D_WIDTH  read data, shared; valid while the matching Ack is high
  Busy  out  1  high in any state other than IDLE
  Mem_En  out  1  SRAM enable
  Mem_RW  out  1  SRAM direction, 1=write
  Mem_Addr  out  A_WIDTH  SRAM address
  Mem_Data_In  out  D_WIDTH  SRAM write data
  Mem_Data_Out  in  D_WIDTH  SRAM registered read data
REQ-004 The block SHALL use one clock, Clk; reset Rst SHALL be asynchronous and active-high.

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE, CAPTURE, ACK.
REQ-006 IDLE: if Req0 or Req1 is high, select a winner per REQ-013, latch its RW/Addr/WData and the winner index, go to ISSUE; else remain in IDLE.
REQ-007 ISSUE: Mem_En=1 for exactly this one cycle, Mem_RW/Mem_Addr/Mem_Data_In driven from the latched values; next state CAPTURE if read, ACK if write.
REQ-008 CAPTURE: RData SHALL be loaded from Mem_Data_Out at the end of this cycle (the SRAM drives read data only in the cycle after the enabling cycle and zero otherwise); next state ACK.
REQ-009 ACK: the winner's Ack SHALL be high for exactly this one cycle; the other Ack SHALL stay low; next state IDLE.
REQ-010 Latency from the IDLE edge that samples a request: write Ack in cycle 2, read Ack in cycle 3; one transaction in flight at most.
REQ-011 Outside ISSUE, Mem_En SHALL be 0; Mem_RW/Mem_Addr/Mem_Data_In SHALL hold their latched values.
REQ-012 Requesters SHALL hold Req and payload stable until Ack and drop Req at the edge where Ack is high; the arbiter SHALL ignore Req/payload changes outside IDLE.
REQ-013 Arbitration: a single requester is always granted; on simultaneous requests the winner is per REQ-020.
REQ-014 RData SHALL hold its last captured value until the next CAPTURE; writes SHALL NOT modify RData.
REQ-015 A request on one port arriving while the other is being served SHALL wait, never be dropped, and be granted on the next IDLE.

Reset
REQ-016 While Rst is high: state=IDLE, Ack0=Ack1=0, Busy=0, Mem_En=0, Mem_RW=0, Mem_Addr=0, Mem_Data_In=0, RData=0, latched request=0, round-robin pointer=0.
REQ-017 Rst asserted mid-transaction SHALL abort it immediately with no Ack issued and no further Mem_En pulse; a write already enabled in ISSUE may have completed in the SRAM.
REQ-018 After Rst deasserts, the first edge SHALL evaluate IDLE normally.
REQ-019 The SRAM's own reset SHALL be driven from the same Rst net outside this block.

Configuration
REQ-020 Macro SRAM_ARB_RR_EN: defined -> round-robin; on a tie the port not granted most recently wins, and the pointer updates on every grant (reset value: port 0 last granted, so port 1 wins the first tie); undefined -> fixed priority, port 0 always wins a tie and no pointer register exists.

Verification
REQ-021 Reset: Rst pulsed mid-read (in CAPTURE) -> all outputs at REQ-016 values on the same cycle, no Ack afterwards.
REQ-022 Write-then-read: port 0 writes 8'hA5 to 13'h0010, then reads it -> write Ack0 on cycle 2, read Ack0 on cycle 3 with RData=8'hA5; Mem_En high exactly 1 cycle per transaction.
REQ-023 Tie: Req0 and Req1 both raised in the same cycle, each writes a different address -> with SRAM_ARB_RR_EN, order 1,0; without it, order 0,1.
REQ-024 Starvation: Req0 held continuously for 4 transactions while Req1 is high -> with SRAM_ARB_RR_EN, grants alternate 1,0,1,0...; without it, port 1 is served only after Req0 drops.
REQ-025 Boundary address: port 1 writes 8'hFF to 13'h1FFF, then port 0 reads 13'h1FFF -> RData=8'hFF with Ack0 only; RData unchanged by intervening writes.
REQ-026 Payload change outside IDLE: port 0 changes Addr0 during ISSUE -> Mem_Addr keeps the latched value.
